// File: rtl/axi_read_arbiter_pkg.sv
// Shared definitions for the two-requester AXI4 read arbiter.
// Bus widths, burst counter width and the arbiter state encoding.
package axi_read_arbiter_pkg;

    localparam int AXI_ADDR_WIDTH      = 32;
    localparam int AXI_DATA_WIDTH      = 32;
    localparam int AXI_LEN_WIDTH       = 8;
    localparam int AXI_BURST_CNT_WIDTH = 9;

    typedef enum logic [1:0] {
        IDLE,
        ADDR,
        DATA
    } read_arb_state_t;

    // Number of beats in a burst: arlen + 1, range 1..256.
    function automatic logic [AXI_BURST_CNT_WIDTH-1:0] burst_beats(
        input logic [AXI_LEN_WIDTH-1:0] len
    );
        return AXI_BURST_CNT_WIDTH'(len) + AXI_BURST_CNT_WIDTH'(1);
    endfunction

endpackage

// File: rtl/axi_read_arbiter_if.sv
// Reduced AXI4 bus: full read address/data handshake and write
// handshakes only (the shared resource is read-only).
interface axi4_interface;
    import axi_read_arbiter_pkg::*;

    logic                      m_arvalid;
    logic [AXI_ADDR_WIDTH-1:0] m_araddr;
    logic [AXI_LEN_WIDTH-1:0]  m_arlen;
    logic                      s_arready;

    logic                      s_rvalid;
    logic [AXI_DATA_WIDTH-1:0] s_rdata;
    logic                      m_rready;

    logic                      m_awvalid;
    logic                      s_awready;
    logic                      m_wvalid;
    logic                      s_wready;
    logic                      s_bvalid;
    logic                      m_bready;

    modport master (
        output m_arvalid, m_araddr, m_arlen, m_rready,
        output m_awvalid, m_wvalid, m_bready,
        input  s_arready, s_rvalid, s_rdata,
        input  s_awready, s_wready, s_bvalid
    );

    modport slave (
        input  m_arvalid, m_araddr, m_arlen, m_rready,
        input  m_awvalid, m_wvalid, m_bready,
        output s_arready, s_rvalid, s_rdata,
        output s_awready, s_wready, s_bvalid
    );

endinterface

// File: rtl/axi_read_arbiter_rr.sv
// Two-way round-robin picker; priority flips to the loser
// whenever a grant is taken (update_priority).
module rr_arbiter2 (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [1:0] request,
    input  logic       update_priority,
    output logic [1:0] grant_oh
);

    // prio_q = 1 means requester 1 wins a tie.
    logic prio_q;

    // Resolve ties with the current priority holder.
    always_comb begin
        grant_oh = 2'b00;
        unique case (request)
            2'b11:   grant_oh = prio_q ? 2'b10 : 2'b01;
            default: grant_oh = request;
        endcase
    end

    // Hand priority to the requester that did not just win.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            prio_q <= 1'b0;
        end else if (update_priority && (grant_oh != 2'b00)) begin
            prio_q <= grant_oh[0];
        end
    end

endmodule

// File: rtl/axi_read_arbiter.sv
// Shares one read-only AXI slave between two requesters, one burst
// at a time; beats are counted locally since the slave has no rlast.
module axi_read_arbiter
    import axi_read_arbiter_pkg::*;
(
    input  logic          clk,
    input  logic          reset_n,
    axi4_interface.slave  axi_m0,
    axi4_interface.slave  axi_m1,
    axi4_interface.master axi_s
);

    read_arb_state_t                state_q;
    read_arb_state_t                state_d;
    logic                           grant_q;
    logic [AXI_ADDR_WIDTH-1:0]      addr_q;
    logic [AXI_LEN_WIDTH-1:0]       len_q;
    logic [AXI_BURST_CNT_WIDTH-1:0] cnt_q;

    logic [1:0] request;
    logic [1:0] grant_oh;
    logic       accept;
    logic       win_rready;
    logic       beat;
    logic       last_beat;

    // Requests are masked while reset is held so arready stays low.
    assign request    = {axi_m1.m_arvalid, axi_m0.m_arvalid}
                      & {2{reset_n}};
    assign accept     = (state_q == IDLE) && (grant_oh != 2'b00);
    assign win_rready = grant_q ? axi_m1.m_rready : axi_m0.m_rready;
    assign beat       = (state_q == DATA) && axi_s.s_rvalid && win_rready;
    assign last_beat  = beat
                      && (cnt_q == AXI_BURST_CNT_WIDTH'(1));

    rr_arbiter2 u_rr (
        .clk             (clk),
        .reset_n         (reset_n),
        .request         (request),
        .update_priority (accept),
        .grant_oh        (grant_oh)
    );

    // Next state and all read-channel outputs.
    always_comb begin
        state_d          = state_q;
        axi_m0.s_arready = 1'b0;
        axi_m1.s_arready = 1'b0;
        axi_m0.s_rvalid  = 1'b0;
        axi_m1.s_rvalid  = 1'b0;
        axi_s.m_arvalid  = 1'b0;
        axi_s.m_araddr   = addr_q;
        axi_s.m_arlen    = len_q;
        axi_s.m_rready   = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    axi_m0.s_arready = grant_oh[0];
                    axi_m1.s_arready = grant_oh[1];
                    state_d          = ADDR;
                end
            end
            ADDR: begin
                axi_s.m_arvalid = 1'b1;
                if (axi_s.s_arready) begin
                    state_d = DATA;
                end
            end
            DATA: begin
                axi_m0.s_rvalid = ~grant_q & axi_s.s_rvalid;
                axi_m1.s_rvalid = grant_q & axi_s.s_rvalid;
                axi_s.m_rready  = win_rready;
                if (last_beat) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State, latched request and beat counter.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            grant_q <= 1'b0;
            addr_q  <= '0;
            len_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                grant_q <= grant_oh[1];
                addr_q  <= grant_oh[1] ? axi_m1.m_araddr
                                       : axi_m0.m_araddr;
                len_q   <= grant_oh[1] ? axi_m1.m_arlen
                                       : axi_m0.m_arlen;
            end
            if ((state_q == ADDR) && axi_s.s_arready) begin
                cnt_q <= burst_beats(len_q);
            end else if (beat) begin
                cnt_q <= cnt_q - AXI_BURST_CNT_WIDTH'(1);
            end
        end
    end

    assign axi_m0.s_rdata = axi_s.s_rdata;
    assign axi_m1.s_rdata = axi_s.s_rdata;

    // Writes are accepted and dropped; nothing goes downstream.
    assign axi_m0.s_awready = 1'b1;
    assign axi_m0.s_wready  = 1'b1;
    assign axi_m0.s_bvalid  = 1'b1;
    assign axi_m1.s_awready = 1'b1;
    assign axi_m1.s_wready  = 1'b1;
    assign axi_m1.s_bvalid  = 1'b1;
    assign axi_s.m_awvalid  = 1'b0;
    assign axi_s.m_wvalid   = 1'b0;
    assign axi_s.m_bready   = 1'b1;

    logic unused_write_side;
    assign unused_write_side = ^{axi_m0.m_awvalid, axi_m0.m_wvalid,
                                 axi_m0.m_bready, axi_m1.m_awvalid,
                                 axi_m1.m_wvalid, axi_m1.m_bready,
                                 axi_s.s_awready, axi_s.s_wready,
                                 axi_s.s_bvalid};

endmodule

// File: doc/axi_read_arbiter.md
# axi_read_arbiter

Two-requester AXI4 read-channel arbiter that shares one read-only AXI slave, such as the boot ROM, between two masters, for example the instruction-fetch path and a debug/loader port. It accepts one read burst at a time from either requester and forwards the address phase downstream. It routes the returned data beats back to the winner and counts the beats itself, because the slave provides no last-beat indication. Grant alternates round-robin at burst granularity. Write channels are tied off, since the downstream resource is read-only.

## Interface
- Parameters: none. Address width 32 and data width 32 come from the shared AXI interface definition.
- clk  input  1  system clock; all state updates on the rising edge.
- reset_n  input  1  asynchronous, active-low reset; clears all state immediately on assertion.
- axi_m0  axi4_interface.slave  —  requester 0; wins ties after reset.
- axi_m1  axi4_interface.slave  —  requester 1.
- axi_s  axi4_interface.master  —  shared downstream slave; read channel only.

## Operation
- State machine with three states:
  - IDLE: no burst owned.
  - ADDR: the latched request is presented downstream.
  - DATA: beats are being routed to the winner.
- IDLE:
  - Sample m_arvalid of both requesters. Winner = the only requester asserting; if both assert, the requester holding priority.
  - Assert s_arready combinationally to the winner only, in the same cycle.
  - Latch the winner's m_araddr, m_arlen and the grant index. Next state is ADDR.
- ADDR:
  - Drive axi_s.m_arvalid=1 with the latched address and length.
  - When axi_s.s_arready=1: load the beat counter with arlen+1 (9-bit, range 1..256). Next state is DATA.
- DATA:
  - The winner sees s_rvalid/s_rdata from axi_s; axi_s.m_rready = the winner's m_rready.
  - The loser sees s_rvalid=0.
  - Each cycle with s_rvalid && m_rready decrements the counter.
  - The handshake with counter==1 completes the burst: next state is IDLE, and priority moves to the non-winner.
- Both requesters' s_arready are 0 outside IDLE. A requester holding arvalid waits, and its address must stay stable per AXI rules.
- Write-channel tie-offs:
  - Toward requesters: s_awready=1, s_wready=1, s_bvalid=1. Writes are discarded.
  - Downstream: m_awvalid=0, m_wvalid=0, m_bready=1.
- Unused read sideband (arid, arsize, arburst) is not forwarded. The downstream slave assumes INCR, 32-bit beats.

## Timing
- Reset values:
  - State IDLE; priority = requester 0; beat counter 0.
  - axi_s.m_arvalid=0 and axi_s.m_rready=0.
  - Both requesters: s_arready=0, s_rvalid=0.
- Address latency:
  - Requester arvalid in cycle N sees arready in cycle N, if IDLE.
  - axi_s.m_arvalid is asserted from cycle N+1.
- Data path is combinational pass-through (rvalid, rdata, rready); no added latency.
- Turnaround: after the final beat in cycle M, IDLE in M+1. The next request can be accepted in M+1.
- Back-to-back with the other requester waiting:
  - Grant alternates: 0, 1, 0, 1 …
  - A lone requester is re-granted every burst.
- Simultaneous events:
  - A requester asserting arvalid in the same cycle the final beat completes is not accepted until M+1.
  - A requester deasserting rready stalls the counter; beats are never dropped.
- Reset mid-burst:
  - Outputs return to reset values asynchronously and the counter is cleared.
  - Any partially delivered burst is abandoned. The downstream slave is reset by the same reset_n.

## Structure
- Add a state enum (IDLE/ADDR/DATA) typedef, read_arb_state_t, to the shared defines package.
- Add the beat-count width constant, AXI_BURST_CNT_WIDTH = 9, to the same package.
- A single module is sufficient.
- Optional sub-module: rr_arbiter2, a 2-way round-robin pick, with inputs request[1:0] and update_priority, and output grant_oh[1:0]. It is a reusable candidate for other shared AXI slaves.

## Test plan
- Single request: m0 araddr=0x100, arlen=3, rready=1 → one s_arready pulse to m0; downstream araddr=0x100, arlen=3; exactly 4 beats to m0; m1 sees no rvalid; IDLE afterward.
- Contention: m0 and m1 both assert arvalid in the same cycle after reset (arlen=0 each) → m0 served first, then m1; a repeat from both yields m0 then m1 again, because priority alternates.
- Backpressure: m1 arlen=7, rready toggled 1,0,0,1… → exactly 8 beats delivered in order with the address incrementing by 4 bytes; the counter holds while rready=0.
- Max length: arlen=255 → 256 beats counted without wrap; the burst ends exactly on beat 256.
- Downstream arready held low 5 cycles → arvalid stays high with a stable address; no beats routed; the other requester is not granted meanwhile.
- Reset mid-burst: assert reset_n=0 after beat 2 of 4 → rvalid and arvalid to both sides are 0 immediately; after release, a new m1 request is granted (priority back to m0 but m0 idle) and completes correctly.
